bist_resp_checker: RTL
======================

// Module: bist_resp_checker
// PURPOSE
//   BIST back end that sits between a deterministic pattern generator (det_patgen_if master side) and the SRAM macro.
//   Registers patgen requests onto the SRAM port and delays expected data by the SRAM read latency.
//   Compares read data against expected data and accumulates pass/fail results.
//   Sequences the run (start, drain, done) for the march_cm_enhanced_patgen stage.
// PARAMETERS
//   ADDR_WIDTH     6   SRAM/patgen address width
//   DATA_WIDTH     8   data word width
//   MASK_WIDTH     2   write-mask width; DATA_WIDTH % MASK_WIDTH == 0
//   READ_LATENCY   1   cycles from sram_ce&&!sram_we to sram_rdata valid; >= 1
//   ERR_CNT_WIDTH  16  error counter width
// PORTS
//   clk              in   1              clock
//   rstb             in   1              async active-low reset
//   start            in   1              1-cycle pulse: begin a run
//   pg_en            out  1              enable to patgen
//   pg_addr          in   ADDR_WIDTH     patgen address
//   pg_we            in   1              patgen write
//   pg_re            in   1              patgen read
//   pg_data          in   DATA_WIDTH     patgen write data
//   pg_check         in   DATA_WIDTH     patgen expected read data
//   pg_mask          in   MASK_WIDTH     patgen write mask
//   pg_done          in   1              patgen finished
//   sram_ce          out  1              SRAM access enable
//   sram_we          out  1              SRAM write enable
//   sram_addr        out  ADDR_WIDTH     SRAM address
//   sram_wdata       out  DATA_WIDTH     SRAM write data
//   sram_wmask       out  MASK_WIDTH     SRAM write mask
//   sram_rdata       in   DATA_WIDTH     SRAM read data
//   busy             out  1              run in progress (RUN or DRAIN)
//   done             out  1              sticky; run complete
//   fail             out  1              sticky; at least one mismatch
//   err_count        out  ERR_CNT_WIDTH  mismatching reads; saturates at all-ones
//   first_fail_addr  out  ADDR_WIDTH     address of first mismatch
//   first_fail_exp   out  DATA_WIDTH     expected data of first mismatch
//   first_fail_got   out  DATA_WIDTH     read data of first mismatch
// BEHAVIOUR
//   Reset: all outputs 0; FSM in IDLE; compare pipeline flushed.
//   FSM states and transitions:
//     IDLE  --start-->    RUN
//     RUN   --pg_done-->  DRAIN
//     DRAIN --pipe empty-->  DONE
//     DONE  --start-->    RUN
//     start is ignored in RUN and DRAIN.
//   Entering RUN: clears fail, err_count and first_fail_*; done drops to 0.
//   pg_en is 1 only in RUN. It drops in the same cycle pg_done is sampled.
//   Request stage: the SRAM port is registered with 1 cycle of latency.
//     In RUN, at each edge: sram_ce <= pg_we|pg_re; sram_we <= pg_we; addr/wdata/wmask copied.
//     Outside RUN: sram_ce = sram_we = 0.
//     pg_we && pg_re together: the write wins; no compare is scheduled.
//   Compare pipeline: a READ_LATENCY-deep shift register of {valid, addr, check}.
//     valid is loaded with sram_ce && !sram_we.
//     Compare happens when the pipe head is valid: mismatch = (sram_rdata != head.check).
//     Total latency from pg_re sampled to compare is 1 + READ_LATENCY cycles.
//   On mismatch:
//     fail <= 1.
//     err_count increments, saturating at all-ones (no wrap).
//     first_fail_* is captured only if fail was 0 before this cycle.
//   DRAIN lasts until the request register and the pipeline hold no valid entry, i.e. READ_LATENCY+1 cycles.
//   Compares continue during DRAIN.
//   done rises when DONE is entered and holds until the next start.
//   Back-to-back reads are fully pipelined; no stalls.
//   Reset mid-run: immediate return to IDLE; in-flight compares are discarded.
// CONFIGURATION
//   BIST_FAIL_BITMAP_EN defined:
//     Adds output fail_bits [DATA_WIDTH-1:0].
//     fail_bits accumulates OR of (sram_rdata ^ head.check) over all compares.
//     Cleared on reset and on entering RUN.
//   BIST_FAIL_BITMAP_EN undefined: the port and its logic are absent.
// STRUCTURE
//   Package bist_pkg:
//     typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e.
//     Parameterised struct for a compare-pipe entry.
//   Sub-module bist_delay_pipe: generic N-stage valid+payload shift register with async active-low reset.
//     Used for the compare pipeline.
// TESTING
//   1. Fault-free model, READ_LATENCY=1, run march_cm_enhanced_patgen on 64 words
//      -> done=1, fail=0, err_count=0; sram_addr trails pg_addr by exactly 1 cycle.
//   2. Model bit3 stuck-at-1 at addr 6'h15
//      -> fail=1, first_fail_addr=6'h15, first_fail_exp=8'h00, first_fail_got=8'h08;
//         err_count = number of reads of 6'h15 expecting 0.
//   3. ERR_CNT_WIDTH=4, every read corrupted
//      -> err_count holds 4'hF, no wrap; first_fail_* is the first read address.
//   4. READ_LATENCY=3, read at cycle T
//      -> compare at T+4; done asserts 4 cycles after pg_done is sampled.
//   5. rstb low mid-RUN with an error pending in the pipe
//      -> all outputs 0, err_count=0; the next start runs cleanly.
//   6. BIST_FAIL_BITMAP_EN with faults on bits 0 and 5 at different addresses
//      -> fail_bits=8'h21; start clears it to 8'h00.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared types for the BIST response checker.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;

endpackage

// File: rtl/bist_delay_pipe.sv
// bist_delay_pipe: N-stage valid+payload shift register, async active-low reset.
module bist_delay_pipe #(
    parameter int N = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [N-1:0] v;
    logic [W-1:0] d [N];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            v <= '0;
            for (int i = 0; i < N; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            d[0] <= in_data;
            for (int i = 1; i < N; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign out_valid = v[N-1];
    assign out_data  = d[N-1];

endmodule

// File: rtl/bist_resp_checker.sv
// bist_resp_checker: registers patgen requests onto the SRAM, compares reads, sequences the run.
// Optional BIST_FAIL_BITMAP_EN adds the fail_bits accumulator output.
module bist_resp_checker
    import bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 8,
    parameter int MASK_WIDTH    = 2,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     start,
    output logic                     pg_en,
    input  logic [ADDR_WIDTH-1:0]    pg_addr,
    input  logic                     pg_we,
    input  logic                     pg_re,
    input  logic [DATA_WIDTH-1:0]    pg_data,
    input  logic [DATA_WIDTH-1:0]    pg_check,
    input  logic [MASK_WIDTH-1:0]    pg_mask,
    input  logic                     pg_done,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_wdata,
    output logic [MASK_WIDTH-1:0]    sram_wmask,
    input  logic [DATA_WIDTH-1:0]    sram_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_fail_addr,
    output logic [DATA_WIDTH-1:0]    first_fail_exp,
    output logic [DATA_WIDTH-1:0]    first_fail_got
`ifdef BIST_FAIL_BITMAP_EN
    ,
    output logic [DATA_WIDTH-1:0]    fail_bits
`endif
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] check;
    } cmp_entry_t;

    localparam int CW = $clog2(READ_LATENCY + 1) + 1;

    bist_state_e           state, state_nx;
    logic [CW-1:0]         drain_cnt;
    logic [DATA_WIDTH-1:0] chk_q;
    logic                  run_start, head_v, mismatch;
    cmp_entry_t            pipe_in, head;

    always_comb begin
        state_nx = state;
        if ((state == IDLE || state == DONE) && start) state_nx = RUN;
        if (state == RUN && pg_done) state_nx = DRAIN;
        // fixed-length drain: by then the last read has been compared
        if (state == DRAIN && drain_cnt == CW'(READ_LATENCY)) state_nx = DONE;
    end

    assign run_start = (state_nx == RUN) && (state != RUN);
    assign pg_en     = (state == RUN) && !pg_done;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_wmask <= '0;
            chk_q      <= '0;
        end else begin
            sram_ce <= (state == RUN) && (pg_we || pg_re);
            sram_we <= (state == RUN) && pg_we;
            if (state == RUN) begin
                sram_addr  <= pg_addr;
                sram_wdata <= pg_data;
                sram_wmask <= pg_mask;
                chk_q      <= pg_check;
            end
        end
    end

    assign pipe_in = '{addr: sram_addr, check: chk_q};

    bist_delay_pipe #(.N(READ_LATENCY), .W($bits(cmp_entry_t))) u_pipe (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (sram_ce && !sram_we),
        .in_data   (pipe_in),
        .out_valid (head_v),
        .out_data  (head)
    );

    assign mismatch = head_v && (sram_rdata != head.check);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fail            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_exp  <= '0;
            first_fail_got  <= '0;
        end else if (run_start) begin
            fail            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_exp  <= '0;
            first_fail_got  <= '0;
        end else if (mismatch) begin
            fail      <= 1'b1;
            err_count <= (&err_count) ? err_count : err_count + ERR_CNT_WIDTH'(1);
            if (!fail) begin
                first_fail_addr <= head.addr;
                first_fail_exp  <= head.check;
                first_fail_got  <= sram_rdata;
            end
        end
    end

`ifdef BIST_FAIL_BITMAP_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) fail_bits <= '0;
        else if (run_start) fail_bits <= '0;
        else if (head_v) fail_bits <= fail_bits | (sram_rdata ^ head.check);
    end
`endif

endmodule
